// File: rtl/stream_frame_pkg.sv
// Shared types and constants for the stream frame writer and its LFSR.
package stream_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [7:0]  HDR_MAGIC_DEF      = 8'hA5;
  localparam logic [15:0] LFSR_ZERO_SEED_DEF = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS          = 16'hB400;

  localparam logic PAT_INC  = 1'b0;
  localparam logic PAT_LFSR = 1'b1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Loadable 16-bit Fibonacci LFSR; a zero seed is replaced so it never locks up.
module lfsr16
  import stream_frame_pkg::*;
#(
  parameter logic [15:0] ZERO_SEED = LFSR_ZERO_SEED_DEF
) (
  input  logic        clock1,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value,
  output logic [15:0] next_value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == 16'h0000) ? ZERO_SEED : seed;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clock1 or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value      = value_q;
  assign next_value = lfsr_next(value_q);

endmodule

// File: rtl/stream_frame_writer.sv
// Framed burst source for the buffer write port: header, payload, optional checksum.
// Checksum word is enabled by defining STREAM_FRAME_WRITER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start; parameters latched on start
// HEADER  | presenting {HDR_MAGIC,length}
// PAYLOAD | presenting payload words, rem_q counts down what is left
// CHECK   | presenting the 16-bit sum of header and payload
// DONE    | one cycle with write request dropped; raises done
module stream_frame_writer
  import stream_frame_pkg::*;
#(
  parameter logic [7:0]  HDR_MAGIC      = HDR_MAGIC_DEF,
  parameter logic [15:0] LFSR_ZERO_SEED = LFSR_ZERO_SEED_DEF
) (
  input  logic        clock1,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  length,
  input  logic        pattern,
  input  logic [15:0] seed,
  input  logic        buffer_full,
  output logic [15:0] data_1,
  output logic        data_1_en,
  output logic        busy,
  output logic        done,
  output logic [8:0]  words_sent
);

  state_e      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [8:0]  words_q, words_d;
  logic [7:0]  rem_q, rem_d;
  logic        pat_q, pat_d;
  logic [15:0] seed_q, seed_d;
`ifdef STREAM_FRAME_WRITER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
`endif

  logic        accept;
  logic        lfsr_load, lfsr_adv;
  logic [15:0] lfsr_value, lfsr_succ;

  lfsr16 #(.ZERO_SEED(LFSR_ZERO_SEED)) u_lfsr (
    .clock1     (clock1),
    .reset      (reset),
    .load       (lfsr_load),
    .step       (lfsr_adv),
    .seed       (seed),
    .value      (lfsr_value),
    .next_value (lfsr_succ)
  );

  // Same condition the buffer uses to write, so nothing is lost while full.
  assign accept = en_q & ~buffer_full;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    en_d      = en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    words_d   = words_q;
    rem_d     = rem_q;
    pat_d     = pat_q;
    seed_d    = seed_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
`ifdef STREAM_FRAME_WRITER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    if (accept) words_d = words_q + 9'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = length;
          pat_d     = pattern;
          seed_d    = seed;
          lfsr_load = 1'b1;
          data_d    = {HDR_MAGIC, length};
          en_d      = 1'b1;
          busy_d    = 1'b1;
          words_d   = 9'd0;
`ifdef STREAM_FRAME_WRITER_CHECKSUM_EN
          sum_d     = {HDR_MAGIC, length};
`endif
          state_d   = HEADER;
        end
      end

      HEADER: begin
        if (accept) begin
          if (rem_q != 8'd0) begin
            data_d  = (pat_q == PAT_LFSR) ? lfsr_value : seed_q;
            state_d = PAYLOAD;
          end else begin
`ifdef STREAM_FRAME_WRITER_CHECKSUM_EN
            data_d  = sum_q;
            state_d = CHECK;
`else
            en_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = DONE;
`endif
          end
        end
      end

      PAYLOAD: begin
        if (accept) begin
          rem_d = rem_q - 8'd1;
`ifdef STREAM_FRAME_WRITER_CHECKSUM_EN
          sum_d = sum_q + data_q;
`endif
          if (rem_q == 8'd1) begin
`ifdef STREAM_FRAME_WRITER_CHECKSUM_EN
            data_d  = sum_q + data_q;
            state_d = CHECK;
`else
            en_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = DONE;
`endif
          end else if (pat_q == PAT_LFSR) begin
            lfsr_adv = 1'b1;
            data_d   = lfsr_succ;
          end else begin
            data_d = data_q + 16'd1;
          end
        end
      end

`ifdef STREAM_FRAME_WRITER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      words_q <= '0;
      rem_q   <= '0;
      pat_q   <= PAT_INC;
      seed_q  <= '0;
`ifdef STREAM_FRAME_WRITER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      words_q <= words_d;
      rem_q   <= rem_d;
      pat_q   <= pat_d;
      seed_q  <= seed_d;
`ifdef STREAM_FRAME_WRITER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign data_1     = data_q;
  assign data_1_en  = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_sent = words_q;

endmodule
